// File: rtl/kgp_encode_stage_if.sv
// Handshake bundle for the KGP encode stage.
//   in_*   : operand pair, carry-in and user tag offered by the source
//            (valid/ready handshake, in_ready driven by the stage)
//   out_*  : packed kill/propagate/generate vector and its tag presented
//            downstream (valid/ready handshake, out_ready driven by the sink)
//   count  : output FIFO occupancy, 0..DEPTH
// master = source/sink side (testbench or neighbouring stages), slave = stage.
interface kgp_encode_stage_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_a;
  logic [WIDTH-1:0]         in_b;
  logic                     in_cin;
  logic [TAGW-1:0]          in_tag;
  logic                     out_valid;
  logic                     out_ready;
  logic [2*(WIDTH+1)-1:0]   out_kgp;
  logic [TAGW-1:0]          out_tag;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_tag, out_ready,
    input  in_ready, out_valid, out_kgp, out_tag, count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_tag, out_ready,
    output in_ready, out_valid, out_kgp, out_tag, count
  );
endinterface

// File: rtl/kgp_encode_stage.sv
// Front stage of the prefix carry network.
// Registers each operand pair already encoded into a (WIDTH+1)-entry
// kill/propagate/generate vector (entry 0 = carry-in, entry i = bit i-1),
// then queues it in a small FIFO whose head register drives the outputs.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous reset, active-low
//   bus    : kgp_encode_stage_if.slave (in_* handshake, out_* handshake,
//            FIFO occupancy on count)
// Encoding per entry: 00 kill, 01 propagate, 11 generate (10 never produced).
module kgp_encode_stage #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  kgp_encode_stage_if.slave  bus
);

  localparam int KW = 2 * (WIDTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [PW-1:0] PINC_C = PW'(1);

  // Generate bit = a&b, propagate-or-generate bit = a|b; this yields
  // 11 / 01 / 00 and can never form 10.
  function automatic logic [KW-1:0] kgp_encode(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             cin
  );
    logic [KW-1:0] v;
    v      = '0;
    v[1:0] = {cin, cin};
    for (int i = 0; i < WIDTH; i++) begin
      v[2*i+3 -: 2] = {a[i] & b[i], a[i] | b[i]};
    end
    return v;
  endfunction

  logic              s1_valid;
  logic [KW-1:0]     s1_kgp;
  logic [TAGW-1:0]   s1_tag;

  logic [KW-1:0]     mem_kgp [DEPTH];
  logic [TAGW-1:0]   mem_tag [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_nxt;
  logic [CW-1:0]     count;
  logic [KW-1:0]     head_kgp;
  logic [TAGW-1:0]   head_tag;

  logic              in_ready;
  logic              out_valid;
  logic              accept;
  logic              pop;
  logic              push;
  logic              not_full;

  // in_ready looks only at registered state, never at out_ready.
  assign not_full  = (count < FULL_C);
  assign in_ready  = ~s1_valid | not_full;
  assign out_valid = (count != '0);
  assign accept    = bus.in_valid & in_ready;
  assign pop       = out_valid & bus.out_ready;
  // A full FIFO still takes s1 when the head leaves in the same cycle.
  assign push      = s1_valid & (not_full | pop);
  assign rd_nxt    = rd_ptr + PINC_C;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_kgp   = head_kgp;
  assign bus.out_tag   = head_tag;
  assign bus.count     = count;

  // ---- stage 1: encode and register the accepted operand pair ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
    end else if (push) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_kgp <= kgp_encode(bus.in_a, bus.in_b, bus.in_cin);
      s1_tag <= bus.in_tag;
    end
  end

  // ---- stage 2: output FIFO storage and pointers ----
  always_ff @(posedge clk) begin
    if (push) begin
      mem_kgp[wr_ptr] <= s1_kgp;
      mem_tag[wr_ptr] <= s1_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PINC_C;
      end
      if (pop) begin
        rd_ptr <= rd_nxt;
      end
      case ({push, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end

  // Head register: holds the entry at rd_ptr while the FIFO is non-empty and
  // keeps the last presented value once it drains. When the FIFO is empty,
  // or holds only the entry being popped, the incoming s1 entry is not in
  // mem yet, so it is forwarded straight from s1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_kgp <= '0;
      head_tag <= '0;
    end else if (pop && (count > ONE_C)) begin
      head_kgp <= mem_kgp[rd_nxt];
      head_tag <= mem_tag[rd_nxt];
    end else if (push && ((count == '0) || (pop && (count == ONE_C)))) begin
      head_kgp <= s1_kgp;
      head_tag <= s1_tag;
    end
  end

endmodule

// File: tb/tb_kgp_encode_stage.sv
// Self-checking bench for kgp_encode_stage: directed scenarios plus random
// operands, checked against a per-bit arithmetic encoding model and a queue
// of accepted transactions.
module tb_kgp_encode_stage;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int TAGW  = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  int   last_acc_cyc;

  logic [33:0] exp_kgp[$];
  logic [3:0]  exp_tag[$];
  logic [33:0] got_kgp[$];
  logic [3:0]  got_tag[$];
  int          got_cyc[$];

  kgp_encode_stage_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAGW(TAGW)) bus ();

  kgp_encode_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Records every pop seen at a clock edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      got_kgp.push_back(bus.out_kgp);
      got_tag.push_back(bus.out_tag);
      got_cyc.push_back(cyc);
    end
  end

  // Reference: entry value = number of set operand bits (2 -> generate 3).
  function automatic logic [33:0] ref_kgp(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin);
    logic [33:0] v;
    int s;
    v = cin ? 34'd3 : 34'd0;
    for (int i = 0; i < 16; i++) begin
      s = int'(a[i]) + int'(b[i]);
      v = v | (34'(s == 2 ? 3 : s) << (2 * i + 2));
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic clear_q();
    exp_kgp.delete(); exp_tag.delete();
    got_kgp.delete(); got_tag.delete(); got_cyc.delete();
  endtask

  // Offers one operand pair and returns after the edge that accepts it.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic [3:0] tag, output int stalls);
    stalls = 0;
    bus.in_valid = 1'b1;
    bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_tag = tag;
    while (!bus.in_ready && stalls < 50) begin
      tick();
      stalls++;
    end
    checks++;
    if (!bus.in_ready) begin
      errors++;
      $display("FAIL send_timeout tag=%0h in_ready=%0b required 1", tag, bus.in_ready);
    end else begin
      exp_kgp.push_back(ref_kgp(a, b, cin));
      exp_tag.push_back(tag);
      tick();
      last_acc_cyc = cyc;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0;
    bus.in_tag = '0; bus.out_ready = 1'b0;
    repeat (3) tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b need 0", bus.out_valid); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d need 0", bus.count); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b need 1", bus.in_ready); end
    checks++; if (bus.out_kgp !== 34'h0) begin errors++; $display("FAIL rst_out_kgp got %h need 0", bus.out_kgp); end
    checks++; if (bus.out_tag !== 4'h0) begin errors++; $display("FAIL rst_out_tag got %h need 0", bus.out_tag); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero_latency();
    int st;
    clear_q();
    bus.out_ready = 1'b1;
    send(16'h0000, 16'h0000, 1'b0, 4'h5, st);
    idle();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t1_early_valid got %0b need 0", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL t1_valid got %0b need 1", bus.out_valid); end
    checks++; if (bus.out_kgp !== 34'h0) begin errors++; $display("FAIL t1_kgp got %h need 0", bus.out_kgp); end
    checks++; if (bus.out_tag !== 4'h5) begin errors++; $display("FAIL t1_tag got %h need 5", bus.out_tag); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t1_one_cycle got %0b need 0", bus.out_valid); end
  endtask

  task automatic test_mixed_encoding();
    int st;
    clear_q();
    bus.out_ready = 1'b1;
    send(16'hFFFF, 16'h0001, 1'b1, 4'h9, st);
    idle();
    tick();
    // entry0=11, entry1=11 (1&1), entries 2..16=01
    checks++; if (bus.out_kgp !== 34'h1_5555_555F) begin errors++; $display("FAIL t2_kgp got %h need 1_5555_555f", bus.out_kgp); end
    checks++; if (bus.out_kgp !== ref_kgp(16'hFFFF, 16'h0001, 1'b1)) begin errors++; $display("FAIL t2_model got %h need %h", bus.out_kgp, ref_kgp(16'hFFFF, 16'h0001, 1'b1)); end
    checks++; if (bus.out_tag !== 4'h9) begin errors++; $display("FAIL t2_tag got %h need 9", bus.out_tag); end
    tick();
  endtask

  task automatic test_fill_stall();
    int st;
    int n;
    logic [15:0] a6, b6;
    clear_q();
    bus.out_ready = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom), 4'(t), st);
    end
    a6 = 16'($urandom); b6 = 16'($urandom);
    bus.in_a = a6; bus.in_b = b6; bus.in_cin = 1'b1; bus.in_tag = 4'd6; bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL t3_in_ready cyc%0d got %0b need 0", k, bus.in_ready); end
      checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL t3_count cyc%0d got %0d need 4", k, bus.count); end
      checks++; if (bus.out_tag !== 4'd1 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL t3_head cyc%0d got tag %0d valid %0b need tag 1 valid 1", k, bus.out_tag, bus.out_valid); end
      tick();
    end
    bus.out_ready = 1'b1;
    send(a6, b6, 1'b1, 4'd6, st);
    idle();
    n = 0;
    while (got_tag.size() < 6 && n < 50) begin tick(); n++; end
    checks++; if (got_tag.size() != 6) begin errors++; $display("FAIL t3_pop_count got %0d need 6", got_tag.size()); end
    for (int i = 0; i < got_tag.size() && i < 6; i++) begin
      checks++; if (got_tag[i] !== exp_tag[i]) begin errors++; $display("FAIL t3_tag[%0d] got %0d need %0d", i, got_tag[i], exp_tag[i]); end
      checks++; if (got_kgp[i] !== exp_kgp[i]) begin errors++; $display("FAIL t3_kgp[%0d] got %h need %h", i, got_kgp[i], exp_kgp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int st;
    int stalls;
    int n;
    int first_acc;
    clear_q();
    bus.out_ready = 1'b1;
    stalls = 0;
    first_acc = 0;
    for (int i = 0; i < 100; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom), 4'($urandom), st);
      stalls += st;
      if (i == 0) first_acc = last_acc_cyc;
    end
    idle();
    n = 0;
    while (got_tag.size() < 100 && n < 50) begin tick(); n++; end
    checks++; if (stalls != 0) begin errors++; $display("FAIL t4_stalls got %0d need 0", stalls); end
    checks++; if (got_tag.size() != 100) begin errors++; $display("FAIL t4_pop_count got %0d need 100", got_tag.size()); end
    if (got_cyc.size() > 0) begin
      checks++; if (got_cyc[0] != first_acc + 2) begin errors++; $display("FAIL t4_latency got %0d need %0d", got_cyc[0] - first_acc, 2); end
    end
    for (int i = 0; i < got_tag.size() && i < 100; i++) begin
      checks++; if (got_kgp[i] !== exp_kgp[i] || got_tag[i] !== exp_tag[i]) begin errors++; $display("FAIL t4_vec[%0d] got %h/%h need %h/%h", i, got_kgp[i], got_tag[i], exp_kgp[i], exp_tag[i]); end
      checks++; if (got_cyc[i] != got_cyc[0] + i) begin errors++; $display("FAIL t4_rate[%0d] got cycle %0d need %0d", i, got_cyc[i], got_cyc[0] + i); end
    end
  endtask

  task automatic test_full_push_pop();
    int st;
    int n;
    clear_q();
    bus.out_ready = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom), 4'(t), st);
    end
    idle();
    checks++; if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL t5_full got count %0d in_ready %0b need 4 0", bus.count, bus.in_ready); end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL t5_push_pop_count got %0d need 4", bus.count); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL t5_in_ready got %0b need 1", bus.in_ready); end
    send(16'($urandom), 16'($urandom), 1'($urandom), 4'd6, st);
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL t5_accept_pop_count got %0d need 3", bus.count); end
    send(16'($urandom), 16'($urandom), 1'($urandom), 4'd7, st);
    checks++; if (bus.count !== 3'd3 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL t5_steady got count %0d in_ready %0b need 3 1", bus.count, bus.in_ready); end
    idle();
    n = 0;
    while (got_tag.size() < 7 && n < 50) begin tick(); n++; end
    checks++; if (got_tag.size() != 7) begin errors++; $display("FAIL t5_pop_count got %0d need 7", got_tag.size()); end
    for (int i = 0; i < got_tag.size() && i < 7; i++) begin
      checks++; if (got_kgp[i] !== exp_kgp[i] || got_tag[i] !== exp_tag[i]) begin errors++; $display("FAIL t5_vec[%0d] got %h/%h need %h/%h", i, got_kgp[i], got_tag[i], exp_kgp[i], exp_tag[i]); end
    end
  endtask

  task automatic test_reset_midflight();
    int st;
    int n;
    clear_q();
    bus.out_ready = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      send(16'($urandom) | 16'h1, 16'($urandom) | 16'h1, 1'b1, 4'(t + 10), st);
    end
    idle();
    checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL t6_pre_count got %0d need 2", bus.count); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_q();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t6_out_valid got %0b need 0", bus.out_valid); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL t6_count got %0d need 0", bus.count); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL t6_in_ready got %0b need 1", bus.in_ready); end
    checks++; if (bus.out_kgp !== 34'h0 || bus.out_tag !== 4'h0) begin errors++; $display("FAIL t6_out_data got %h/%h need 0/0", bus.out_kgp, bus.out_tag); end
    bus.out_ready = 1'b1;
    send(16'h1234, 16'h00FF, 1'b0, 4'hA, st);
    idle();
    n = 0;
    while (got_tag.size() < 1 && n < 20) begin tick(); n++; end
    repeat (3) tick();
    checks++; if (got_tag.size() != 1) begin errors++; $display("FAIL t6_pop_count got %0d need 1", got_tag.size()); end
    if (got_tag.size() > 0) begin
      checks++; if (got_kgp[0] !== exp_kgp[0] || got_tag[0] !== 4'hA) begin errors++; $display("FAIL t6_first got %h/%h need %h/a", got_kgp[0], got_tag[0], exp_kgp[0]); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    last_acc_cyc = 0;
    test_reset();
    test_zero_latency();
    test_mixed_encoding();
    test_fill_stall();
    test_back_to_back();
    test_full_push_pop();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
